diad_memarb: RTL and testbench
==============================

Name: diad_memarb

Overview:
- Arbitrates the single shared memory port between the instruction-fetch stage (IF, read-only) and the memory-access stage (MA, read/write) of the diad pipeline.
- Issues at most one access per cycle. The memory is pipelined with fixed read latency.
- Routes read data back to the requester that issued it and drives per-stage stall signals.
- Supports a branch flush that discards in-flight fetch responses.

Parameters:
- ADDR_W, 24, address width of both requesters and the memory port.
- DATA_W, 24, data width.
- LATENCY, 2, cycles from ow_mem_en to valid iw_mem_rdata (legal range 1..4).
- MAX_WAIT, 3, consecutive IF denials after which IF gets priority for one grant (legal range 1..15).

Ports:
- iw_clk  in  1  clock, rising edge
- iw_rst  in  1  synchronous reset, active-high
- iw_if_req  in  1  IF read request
- iw_if_addr  in  ADDR_W  IF address
- ow_if_gnt  out  1  IF request accepted this cycle
- ow_if_rvalid  out  1  IF read data valid
- ow_if_rdata  out  DATA_W  IF read data
- ow_if_stall  out  1  iw_if_req & ~ow_if_gnt
- iw_ma_req  in  1  MA request
- iw_ma_we  in  1  MA write enable
- iw_ma_addr  in  ADDR_W  MA address
- iw_ma_wdata  in  DATA_W  MA write data
- ow_ma_gnt  out  1  MA request accepted this cycle
- ow_ma_rvalid  out  1  MA read data valid (reads only)
- ow_ma_rdata  out  DATA_W  MA read data
- ow_ma_stall  out  1  iw_ma_req & ~ow_ma_gnt
- iw_flush  in  1  pipeline flush; kills IF responses in flight
- ow_mem_en  out  1  memory access strobe
- ow_mem_we  out  1  memory write
- ow_mem_addr  out  ADDR_W  memory address
- ow_mem_wdata  out  DATA_W  memory write data
- iw_mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after a read strobe

Behaviour:
- Reset: iw_rst=1 at a rising edge clears the starvation counter and the in-flight tag pipe. All registered outputs (ow_*_rvalid, ow_*_rdata) go to 0. Reset mid-operation discards every outstanding response; no rvalid is produced for it.
- Grant logic is combinational and in the same cycle as the request. ow_mem_* are combinational from the winning request. ow_*_gnt and ow_mem_en are forced to 0 while iw_rst=1.
- Priority: MA wins by default (older instruction). IF wins when starve_cnt == MAX_WAIT.
- Grant conditions: when only one request is asserted, it is granted. When neither is asserted, ow_mem_en=0.
- Stall: a requester not granted keeps req, addr and wdata stable until it sees gnt.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) each cycle IF requests and is denied.
  - Clears on any IF grant.
  - Clears when iw_if_req=0.
- Tag pipe: shift register of depth LATENCY, each entry holding {valid, owner}.
  - On each grant of a read, a valid entry is pushed with owner IF or MA. MA writes push an invalid entry.
  - The entry exiting at stage LATENCY selects the rvalid target. iw_mem_rdata is registered into ow_*_rdata, and the matching ow_*_rvalid pulses for 1 cycle.
  - Response therefore appears LATENCY+1 cycles after the grant edge (grant in cycle N, rvalid high in cycle N+LATENCY+1).
- Throughput: fully pipelined, one grant per cycle, back-to-back grants allowed. Responses return in issue order.
- Flush: iw_flush=1 clears the valid bit of every in-flight IF entry, including one granted in the same cycle. MA entries are unaffected. An IF rvalid scheduled for the flush cycle's output edge is suppressed.
- Writes: a write is complete at grant. There is no response and no rvalid.
- Read-after-write: MA write then MA read of the same address must return the new data. Memory ordering guarantees this; the arbiter must not reorder.
- Simultaneous flush and IF grant: the grant is issued (memory access happens) but its response is dropped.

Test Plan:
- IF-only read, addr 0x000010, memory holds 0x00ABCD, LATENCY=2 -> ow_if_gnt same cycle; ow_if_rvalid=1 with rdata 0x00ABCD exactly 3 cycles after grant; ow_if_stall=0.
- IF and MA read requested together (MA addr 0x20) -> ow_ma_gnt=1, ow_if_gnt=0, ow_if_stall=1. IF is granted the next cycle if MA drops req.
- MA requests continuously, IF held, MAX_WAIT=3 -> IF denied 3 cycles, granted on the 4th, MA stalled that cycle. starve_cnt returns to 0.
- 4 back-to-back IF reads, addrs 0x0–0x3 -> 4 consecutive grants; 4 consecutive rvalids in address order with correct data.
- Two IF reads in flight, then iw_flush=1 -> neither produces ow_if_rvalid. An MA read issued the cycle before the flush still returns with rvalid.
- MA write 0x123456 to 0x40, then reset asserted with an IF read in flight, then reset released -> no rvalid after reset. Subsequent MA read of 0x40 returns 0x123456.

Source files
------------

// File: rtl/diad_memarb.sv
// Shared memory-port arbiter for the diad pipeline: IF (read-only) vs MA (read/write),
// with a starvation override for IF, an in-flight owner tag pipe and branch flush.
module diad_memarb #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 24,
    parameter int LATENCY  = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_if_req,
    input  logic [ADDR_W-1:0] iw_if_addr,
    output logic              ow_if_gnt,
    output logic              ow_if_rvalid,
    output logic [DATA_W-1:0] ow_if_rdata,
    output logic              ow_if_stall,
    input  logic              iw_ma_req,
    input  logic              iw_ma_we,
    input  logic [ADDR_W-1:0] iw_ma_addr,
    input  logic [DATA_W-1:0] iw_ma_wdata,
    output logic              ow_ma_gnt,
    output logic              ow_ma_rvalid,
    output logic [DATA_W-1:0] ow_ma_rdata,
    output logic              ow_ma_stall,
    input  logic              iw_flush,
    output logic              ow_mem_en,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata
);

    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [LATENCY-1:0] tag_if_q, tag_if_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               ma_rvalid_q, ma_rvalid_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  ma_rdata_q, ma_rdata_d;

    logic if_prio;
    logic if_win;
    logic ma_win;
    logic exit_v;
    logic exit_if;

    assign if_prio = (starve_cnt_q == 4'(MAX_WAIT));
    assign if_win  = ~iw_rst & iw_if_req & (~iw_ma_req | if_prio);
    assign ma_win  = ~iw_rst & iw_ma_req & (~iw_if_req | ~if_prio);

    assign ow_if_gnt    = if_win;
    assign ow_ma_gnt    = ma_win;
    assign ow_if_stall  = iw_if_req & ~if_win;
    assign ow_ma_stall  = iw_ma_req & ~ma_win;

    assign ow_mem_en    = if_win | ma_win;
    assign ow_mem_we    = ma_win & iw_ma_we;
    assign ow_mem_addr  = ma_win ? iw_ma_addr : iw_if_addr;
    assign ow_mem_wdata = iw_ma_wdata;

    // Flush kills IF tags at every stage, including the one leaving the pipe now.
    assign exit_v  = tag_v_q[LATENCY-1] & ~(iw_flush & tag_if_q[LATENCY-1]);
    assign exit_if = tag_if_q[LATENCY-1];

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!iw_if_req || if_win) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < 4'(MAX_WAIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        tag_v_d     = '0;
        tag_if_d    = '0;
        tag_v_d[0]  = (if_win & ~iw_flush) | (ma_win & ~iw_ma_we);
        tag_if_d[0] = if_win;
        for (int i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1] & ~(iw_flush & tag_if_q[i-1]);
            tag_if_d[i] = tag_if_q[i-1];
        end

        if_rvalid_d = exit_v & exit_if;
        ma_rvalid_d = exit_v & ~exit_if;
        if_rdata_d  = if_rvalid_d ? iw_mem_rdata : if_rdata_q;
        ma_rdata_d  = ma_rvalid_d ? iw_mem_rdata : ma_rdata_q;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            starve_cnt_q <= 4'd0;
            tag_v_q      <= '0;
            tag_if_q     <= '0;
            if_rvalid_q  <= 1'b0;
            ma_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ma_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_v_q      <= tag_v_d;
            tag_if_q     <= tag_if_d;
            if_rvalid_q  <= if_rvalid_d;
            ma_rvalid_q  <= ma_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ma_rdata_q   <= ma_rdata_d;
        end
    end

    assign ow_if_rvalid = if_rvalid_q;
    assign ow_ma_rvalid = ma_rvalid_q;
    assign ow_if_rdata  = if_rdata_q;
    assign ow_ma_rdata  = ma_rdata_q;

endmodule

// File: tb/tb_diad_memarb.sv
// Directed bench for diad_memarb with a 2-cycle pipelined memory model.
module tb_diad_memarb;

    logic        iw_clk = 1'b0;
    logic        iw_rst;
    logic        iw_if_req;
    logic [23:0] iw_if_addr;
    logic        ow_if_gnt, ow_if_rvalid, ow_if_stall;
    logic [23:0] ow_if_rdata;
    logic        iw_ma_req, iw_ma_we;
    logic [23:0] iw_ma_addr, iw_ma_wdata;
    logic        ow_ma_gnt, ow_ma_rvalid, ow_ma_stall;
    logic [23:0] ow_ma_rdata;
    logic        iw_flush;
    logic        ow_mem_en, ow_mem_we;
    logic [23:0] ow_mem_addr, ow_mem_wdata;
    logic [23:0] iw_mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [0:255];
    logic [23:0] rd_p1, rd_p2;

    always #5 iw_clk = ~iw_clk;

    diad_memarb #(.ADDR_W(24), .DATA_W(24), .LATENCY(2), .MAX_WAIT(3)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_if_req(iw_if_req), .iw_if_addr(iw_if_addr),
        .ow_if_gnt(ow_if_gnt), .ow_if_rvalid(ow_if_rvalid),
        .ow_if_rdata(ow_if_rdata), .ow_if_stall(ow_if_stall),
        .iw_ma_req(iw_ma_req), .iw_ma_we(iw_ma_we),
        .iw_ma_addr(iw_ma_addr), .iw_ma_wdata(iw_ma_wdata),
        .ow_ma_gnt(ow_ma_gnt), .ow_ma_rvalid(ow_ma_rvalid),
        .ow_ma_rdata(ow_ma_rdata), .ow_ma_stall(ow_ma_stall),
        .iw_flush(iw_flush),
        .ow_mem_en(ow_mem_en), .ow_mem_we(ow_mem_we),
        .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
        .iw_mem_rdata(iw_mem_rdata)
    );

    // Memory model: read data appears two cycles after the strobe cycle.
    always @(posedge iw_clk) begin
        if (ow_mem_en && ow_mem_we) mem[ow_mem_addr[7:0]] <= ow_mem_wdata;
        rd_p1 <= mem[ow_mem_addr[7:0]];
        rd_p2 <= rd_p1;
    end
    assign iw_mem_rdata = rd_p2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle; inputs are driven 1 ns after the edge.
    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic idle();
        iw_if_req  = 1'b0; iw_if_addr = '0;
        iw_ma_req  = 1'b0; iw_ma_we   = 1'b0;
        iw_ma_addr = '0;   iw_ma_wdata = '0;
        iw_flush   = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h5A0000 | 24'(i);
        mem[8'h10] = 24'h00ABCD;
        mem[8'h20] = 24'h00C0DE;
        mem[8'h22] = 24'h00BEEF;
        idle();
        iw_rst = 1'b1;

        // Reset: grants and strobe forced low while reset is high
        tick();
        iw_if_req = 1'b1; iw_ma_req = 1'b1; settle();
        check("rst_if_gnt", 32'(ow_if_gnt), 0);
        check("rst_ma_gnt", 32'(ow_ma_gnt), 0);
        check("rst_mem_en", 32'(ow_mem_en), 0);
        tick();
        idle(); iw_rst = 1'b0; settle();
        check("rst_if_rvalid", 32'(ow_if_rvalid), 0);
        check("rst_ma_rvalid", 32'(ow_ma_rvalid), 0);
        check("rst_if_rdata", 32'(ow_if_rdata), 0);
        tick();

        // IF-only read of 0x10
        iw_if_req = 1'b1; iw_if_addr = 24'h10; settle();
        check("t1_if_gnt", 32'(ow_if_gnt), 1);
        check("t1_if_stall", 32'(ow_if_stall), 0);
        check("t1_mem_en", 32'(ow_mem_en), 1);
        check("t1_mem_addr", 32'(ow_mem_addr), 32'h10);
        for (int k = 1; k <= 4; k++) begin
            tick(); idle(); settle();
            check("t1_if_rvalid", 32'(ow_if_rvalid), (k == 3) ? 1 : 0);
            if (k == 3) check("t1_if_rdata", 32'(ow_if_rdata), 32'h00ABCD);
        end

        // IF and MA together: MA wins, IF follows once MA drops
        iw_if_req = 1'b1; iw_if_addr = 24'h11;
        iw_ma_req = 1'b1; iw_ma_addr = 24'h20; settle();
        check("t2_ma_gnt", 32'(ow_ma_gnt), 1);
        check("t2_if_gnt", 32'(ow_if_gnt), 0);
        check("t2_if_stall", 32'(ow_if_stall), 1);
        check("t2_ma_stall", 32'(ow_ma_stall), 0);
        check("t2_mem_addr", 32'(ow_mem_addr), 32'h20);
        tick();
        iw_ma_req = 1'b0; settle();
        check("t2_if_gnt_next", 32'(ow_if_gnt), 1);
        check("t2_mem_addr_next", 32'(ow_mem_addr), 32'h11);
        for (int k = 2; k <= 5; k++) begin
            tick(); idle(); settle();
            check("t2_ma_rvalid", 32'(ow_ma_rvalid), (k == 3) ? 1 : 0);
            check("t2_if_rvalid", 32'(ow_if_rvalid), (k == 4) ? 1 : 0);
            if (k == 3) check("t2_ma_rdata", 32'(ow_ma_rdata), 32'h00C0DE);
            if (k == 4) check("t2_if_rdata", 32'(ow_if_rdata), 32'h5A0011);
        end

        // Starvation: IF denied 3 cycles, wins the 4th, then counter restarts
        for (int k = 1; k <= 5; k++) begin
            iw_if_req = 1'b1; iw_if_addr = 24'h12;
            iw_ma_req = 1'b1; iw_ma_addr = 24'h21; settle();
            check("t3_if_gnt", 32'(ow_if_gnt), (k == 4) ? 1 : 0);
            check("t3_ma_gnt", 32'(ow_ma_gnt), (k == 4) ? 0 : 1);
            check("t3_ma_stall", 32'(ow_ma_stall), (k == 4) ? 1 : 0);
            tick();
        end
        idle();
        for (int k = 0; k < 5; k++) tick();

        // Four back-to-back IF reads, addresses 0..3
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k < 4) begin
                iw_if_req = 1'b1; iw_if_addr = 24'(k);
            end
            settle();
            if (k < 4) check("t4_if_gnt", 32'(ow_if_gnt), 1);
            check("t4_if_rvalid", 32'(ow_if_rvalid), (k >= 3 && k <= 6) ? 1 : 0);
            if (k >= 3 && k <= 6)
                check("t4_if_rdata", 32'(ow_if_rdata), 32'h5A0000 | 32'(k - 3));
            tick();
        end
        idle();
        tick();

        // Flush: IF reads in flight plus one granted on the flush cycle all die; MA survives
        for (int k = 0; k < 7; k++) begin
            idle();
            if (k == 0) begin iw_if_req = 1'b1; iw_if_addr = 24'h01; end
            if (k == 1) begin iw_ma_req = 1'b1; iw_ma_addr = 24'h22; end
            if (k == 2) begin iw_if_req = 1'b1; iw_if_addr = 24'h02; iw_flush = 1'b1; end
            settle();
            if (k == 2) begin
                check("t5_if_gnt_flush", 32'(ow_if_gnt), 1);
                check("t5_mem_en_flush", 32'(ow_mem_en), 1);
            end
            check("t5_if_rvalid", 32'(ow_if_rvalid), 0);
            check("t5_ma_rvalid", 32'(ow_ma_rvalid), (k == 4) ? 1 : 0);
            if (k == 4) check("t5_ma_rdata", 32'(ow_ma_rdata), 32'h00BEEF);
            tick();
        end
        idle();

        // Write, reset with IF read in flight, then read back the write
        iw_ma_req = 1'b1; iw_ma_we = 1'b1; iw_ma_addr = 24'h40; iw_ma_wdata = 24'h123456; settle();
        check("t6_ma_gnt_wr", 32'(ow_ma_gnt), 1);
        check("t6_mem_we", 32'(ow_mem_we), 1);
        tick();
        idle(); iw_if_req = 1'b1; iw_if_addr = 24'h03; settle();
        check("t6_if_gnt", 32'(ow_if_gnt), 1);
        tick();
        idle(); iw_rst = 1'b1; iw_if_req = 1'b1; settle();
        check("t6_rst_if_gnt", 32'(ow_if_gnt), 0);
        tick();
        idle(); iw_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t6_if_rvalid", 32'(ow_if_rvalid), 0);
            check("t6_ma_rvalid", 32'(ow_ma_rvalid), 0);
            tick();
        end
        check("t6_if_rdata_clr", 32'(ow_if_rdata), 0);
        iw_ma_req = 1'b1; iw_ma_addr = 24'h40; settle();
        check("t6_ma_gnt_rd", 32'(ow_ma_gnt), 1);
        check("t6_mem_we_rd", 32'(ow_mem_we), 0);
        for (int k = 1; k <= 4; k++) begin
            tick(); idle(); settle();
            check("t6_ma_rvalid_rd", 32'(ow_ma_rvalid), (k == 3) ? 1 : 0);
            if (k == 3) check("t6_ma_rdata", 32'(ow_ma_rdata), 32'h123456);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
